// File: rtl/regfile16_onehot_wr.sv
// 16 x WIDTH register file with a one-hot write select, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a registered illegal-select flag.
module regfile16_onehot_wr #(
   parameter int WIDTH    = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [15:0]      wsel,
   input  logic [WIDTH-1:0] wdata,
   input  logic [3:0]       raddr1,
   input  logic [3:0]       raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2,
   output logic             wsel_err
);

   logic [WIDTH-1:0] mem_q [16];
   logic [WIDTH-1:0] mem_d [16];
   logic             err_q;
   logic             err_d;
   logic             wr_legal_s;

   function automatic logic is_onehot16(input logic [15:0] v);
      return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
   endfunction

   // Select one read port's data: zero entry, then same-cycle forward, then stored value.
   function automatic logic [WIDTH-1:0] read_port(
      input logic [3:0]       addr,
      input logic             legal,
      input logic             in_reset_n,
      input logic [15:0]      sel,
      input logic [WIDTH-1:0] wd,
      input logic [WIDTH-1:0] stored
   );
      logic [WIDTH-1:0] r;
      if (ZERO_REG && (addr == 4'd0)) begin
         r = '0;
      end else if (BYPASS && in_reset_n && legal && sel[addr]) begin
         r = wd;
      end else begin
         r = stored;
      end
      return r;
   endfunction

   // Write legality and next-state error flag.
   always_comb begin
      wr_legal_s = we && is_onehot16(wsel);
      err_d      = we && !is_onehot16(wsel);
   end

   // Next-state contents: only the single selected entry loads, entry 0 stays zero when hardwired.
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         mem_d[k] = mem_q[k];
      end
      for (int k = 0; k < 16; k++) begin
         if (wr_legal_s && wsel[k] && !(ZERO_REG && (k == 0))) begin
            mem_d[k] = wdata;
         end else begin
            mem_d[k] = mem_q[k];
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) begin
            mem_q[k] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int k = 0; k < 16; k++) begin
            mem_q[k] <= mem_d[k];
         end
         err_q <= err_d;
      end
   end

   // Combinational read ports.
   always_comb begin
      rdata1 = read_port(raddr1, wr_legal_s, rst_n, wsel, wdata, mem_q[raddr1]);
      rdata2 = read_port(raddr2, wr_legal_s, rst_n, wsel, wdata, mem_q[raddr2]);
   end

   assign wsel_err = err_q;

endmodule

// File: tb/tb_regfile16_onehot_wr.sv
// Directed self-checking bench for regfile16_onehot_wr with default parameters
// (WIDTH=32, ZERO_REG=1, BYPASS=1).
module tb_regfile16_onehot_wr;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [15:0] wsel;
   logic [31:0] wdata;
   logic [3:0]  raddr1;
   logic [3:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        wsel_err;

   int n_checks = 0;
   int n_errors = 0;

   regfile16_onehot_wr dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .wsel     (wsel),
      .wdata    (wdata),
      .raddr1   (raddr1),
      .raddr2   (raddr2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .wsel_err (wsel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One legal write of entry k; returns 1 time unit after the capturing edge.
   task automatic wr(input int k, input logic [31:0] d);
      we    = 1'b1;
      wsel  = 16'd1 << k;
      wdata = d;
      @(posedge clk); #1;
      we    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] exp_v;
      rst_n  = 1'b0;
      we     = 1'b0;
      wsel   = 16'd0;
      wdata  = 32'd0;
      raddr1 = 4'd5;
      raddr2 = 4'd15;
      #2;
      check_val("por_rdata1", rdata1, 32'd0);
      check_val("por_err", {31'd0, wsel_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-operation
      for (int i = 1; i < 16; i++) wr(i, 32'hA5A5_0000 + 32'(i));
      check_val("load_e5", rdata1, 32'hA5A5_0005);
      check_val("load_e15", rdata2, 32'hA5A5_000F);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_rdata1", rdata1, 32'd0);
      check_val("rst_rdata2", rdata2, 32'd0);
      check_val("rst_err", {31'd0, wsel_err}, 32'd0);
      we = 1'b1; wsel = 16'h0020; wdata = 32'hFFFF_0000;
      #1;
      check_val("rst_no_bypass", rdata1, 32'd0);
      tick();
      check_val("rst_write_lost", rdata1, 32'd0);
      we = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      check_val("post_rst_e5", rdata1, 32'd0);
      check_val("post_rst_err", {31'd0, wsel_err}, 32'd0);

      // Legal write with bypass; concurrent read of a different entry sees old value
      we = 1'b1; wsel = 16'h0020; wdata = 32'hDEAD_BEEF; raddr1 = 4'd5; raddr2 = 4'd6;
      #1;
      check_val("bypass_rdata1", rdata1, 32'hDEAD_BEEF);
      check_val("other_entry_old", rdata2, 32'd0);
      tick();
      we = 1'b0;
      check_val("legal_next", rdata1, 32'hDEAD_BEEF);
      check_val("legal_err", {31'd0, wsel_err}, 32'd0);

      // Illegal select: none set
      we = 1'b1; wsel = 16'h0000; wdata = 32'h1111_1111;
      tick();
      we = 1'b0;
      check_val("ill0_err", {31'd0, wsel_err}, 32'd1);
      check_val("ill0_e5", rdata1, 32'hDEAD_BEEF);
      tick();
      check_val("ill0_err_clr", {31'd0, wsel_err}, 32'd0);

      // Illegal select: two bits set, no bypass either
      wr(7, 32'h77);
      wr(8, 32'h88);
      raddr1 = 4'd7; raddr2 = 4'd8;
      we = 1'b1; wsel = 16'h0180; wdata = 32'h2222_2222;
      #1;
      check_val("ill2_no_bypass", rdata1, 32'h77);
      tick();
      we = 1'b0;
      check_val("ill2_err", {31'd0, wsel_err}, 32'd1);
      check_val("ill2_e7", rdata1, 32'h77);
      check_val("ill2_e8", rdata2, 32'h88);

      // Back-to-back illegal writes
      we = 1'b1; wsel = 16'h0003;
      tick();
      check_val("b2b_err1", {31'd0, wsel_err}, 32'd1);
      wsel = 16'hFFFF;
      tick();
      check_val("b2b_err2", {31'd0, wsel_err}, 32'd1);
      we = 1'b0;
      tick();
      check_val("b2b_err_clr", {31'd0, wsel_err}, 32'd0);

      // Zero register
      we = 1'b1; wsel = 16'h0001; wdata = 32'h1234_5678; raddr1 = 4'd0; raddr2 = 4'd0;
      #1;
      check_val("zr_same1", rdata1, 32'd0);
      check_val("zr_same2", rdata2, 32'd0);
      tick();
      we = 1'b0;
      check_val("zr_next1", rdata1, 32'd0);
      check_val("zr_next2", rdata2, 32'd0);
      check_val("zr_err", {31'd0, wsel_err}, 32'd0);

      // Dual read and write-enable gating
      wr(3, 32'h33);
      wr(12, 32'hCC);
      raddr1 = 4'd3; raddr2 = 4'd12;
      #1;
      check_val("dual_r1", rdata1, 32'h33);
      check_val("dual_r2", rdata2, 32'hCC);
      we = 1'b0; wsel = 16'h1000; wdata = 32'h0000_FFFF;
      #1;
      check_val("we0_no_bypass", rdata2, 32'hCC);
      tick();
      check_val("we0_e12", rdata2, 32'hCC);
      check_val("we0_err", {31'd0, wsel_err}, 32'd0);

      // Exhaustive sweep through both ports
      for (int i = 1; i < 16; i++) wr(i, 32'(i) * 32'h0101_0101);
      check_val("sweep_err", {31'd0, wsel_err}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         raddr1 = 4'(i);
         raddr2 = 4'(15 - i);
         #1;
         exp_v = 32'(i) * 32'h0101_0101;
         check_val($sformatf("sweep_r1_%0d", i), rdata1, exp_v);
         exp_v = 32'(15 - i) * 32'h0101_0101;
         check_val($sformatf("sweep_r2_%0d", 15 - i), rdata2, exp_v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
